ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, max CLK_50M cycles between PS/2 falling edges inside one frame (1 ms).
REQ-002 SHALL have port CLK_50M  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous.
REQ-006 SHALL have port ps2_byte  output  8  ASCII code of the held key ("A", "D", "W", "S"), else 8'h00.
REQ-007 SHALL have port ps2_state  output  1  high while a mapped key is held.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; falling edge = synchronized clk 1 -> 0.
REQ-010 Frame FSM SHALL use states IDLE, DATA, PARITY, STOP; IDLE -> DATA on a falling edge with data=0 (start bit); falling edge with data=1 in IDLE ignored.
REQ-011 DATA SHALL shift 8 bits LSB first on 8 falling edges, then PARITY (1 edge), then STOP (1 edge) -> IDLE.
REQ-012 Stop bit sampled 0 SHALL discard the frame and pulse frame_err.
REQ-013 Inter-edge counter SHALL reset on every falling edge; reaching TIMEOUT_CYCLES in a non-IDLE state SHALL return to IDLE, discard partial data, pulse frame_err.
REQ-014 Accepted frame SHALL produce a one-cycle internal code_valid the cycle after the stop-bit edge is detected; ps2_byte/ps2_state SHALL update on the next cycle (latency 2 cycles from stop edge).
REQ-015 Code 8'hE0 SHALL set an extended flag; next code consumed with flag set SHALL clear it and cause no output change.
REQ-016 Code 8'hF0 SHALL set a break flag; next code clears it.
REQ-017 Make code (break flag clear) 8'h1C/8'h23/8'h1D/8'h1B SHALL set ps2_byte to "A"/"D"/"W"/"S" and ps2_state=1, replacing any held key.
REQ-018 Unmapped make codes SHALL leave outputs unchanged.
REQ-019 Break code equal to the held key's scancode SHALL set ps2_state=0, ps2_byte=8'h00; break of any other code SHALL leave outputs unchanged.
REQ-020 Repeated make of the held key (typematic) SHALL keep ps2_state=1 with no glitch.
REQ-021 Timeout and frame error SHALL NOT clear break/extended flags except when the discarded frame was mid-sequence (flags persist only across accepted frames).

Reset
REQ-022 RST SHALL force FSM=IDLE, shift register, bit and timeout counters, flags, held scancode to 0; ps2_byte=8'h00, ps2_state=0, frame_err=0.
REQ-023 RST asserted mid-frame SHALL abandon the frame without frame_err; reception resumes at the next start bit after RST deasserts.

Configuration
REQ-024 With PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit have even 1-count SHALL be discarded with frame_err pulse.
REQ-025 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored; no parity-related frame_err.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state enum, scancode constants (E0, F0, 1C, 23, 1D, 1B) and ASCII constants.
REQ-027 Sub-module ps2_rx_frame SHALL contain synchronizers, frame FSM and timeout, outputting code[7:0], code_valid, frame_err; ps2_key_decoder SHALL hold the make/break decoder.

Verification
REQ-028 Frame 8'h1C, good parity -> ps2_byte="A" (8'h41), ps2_state=1, 2 cycles after stop edge.
REQ-029 Frames 1C, F0, 1C -> ps2_state 1 then 0, ps2_byte 8'h00 after final frame.
REQ-030 Frames 23, F0, 1C -> ps2_byte="D", ps2_state=1 throughout.
REQ-031 Frame 8'h1D with wrong parity -> frame_err pulse, outputs unchanged with PS2_PARITY_CHECK_EN; ps2_byte="W" without.
REQ-032 Start + 4 data bits then clock stops for 50000 cycles -> frame_err pulse, FSM IDLE; next frame 8'h1B -> ps2_byte="S".
REQ-033 Frames E0, 1C -> no output change; RST mid-frame -> all outputs 0, no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and WASD key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_fsm_e;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_A   = 8'h1C;
  localparam logic [7:0] SC_D   = 8'h23;
  localparam logic [7:0] SC_W   = 8'h1D;
  localparam logic [7:0] SC_S   = 8'h1B;

  localparam logic [7:0] ASCII_NONE = 8'h00;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_W    = 8'h57;
  localparam logic [7:0] ASCII_S    = 8'h53;

  // ASCII_NONE marks a scancode outside the WASD set.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
    case (sc)
      SC_A:    return ASCII_A;
      SC_D:    return ASCII_D;
      SC_W:    return ASCII_W;
      SC_S:    return ASCII_S;
      default: return ASCII_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronizers, start/data/parity/stop FSM and inter-edge timeout.
// Odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       code_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_prev_q;
  ps2_fsm_e         state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             fall, din, timeout, par_good;

  // Idle PS/2 lines float high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign din     = dat_sync_q[1];
  assign timeout = (state_q != ST_IDLE) && !fall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_ok_q, par_ok_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) par_ok_q <= 1'b0;
    else       par_ok_q <= par_ok_d;
  end
  always_comb begin
    par_ok_d = par_ok_q;
    if (fall && state_q == ST_PARITY) par_ok_d = ^{shift_q, din};
  end
  assign par_good = par_ok_q;
`else
  assign par_good = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = (state_q == ST_IDLE || fall) ? '0 : cnt_q + CNT_W'(1);
    if (timeout) begin
      state_d = ST_IDLE;
      shift_d = '0;
      bit_d   = '0;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!din) state_d = ST_DATA;
          bit_d = '0;
        end
        ST_DATA: begin
          shift_d = {din, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_PARITY;
          else               bit_d   = bit_q + 3'd1;
        end
        ST_PARITY: state_d = ST_STOP;
        default: begin
          state_d = ST_IDLE;
          bit_d   = '0;
          if (din && par_good) valid_d = 1'b1;
          else                 err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign code_o       = shift_q;
  assign code_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard WASD decoder: tracks make/break/extended prefixes and reports the held key as ASCII.
// Optional odd-parity rejection in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       frame_err
);

  logic [7:0] code, ascii;
  logic       code_valid;
  logic       ext_q, ext_d, brk_q, brk_d, key_q, key_d;
  logic [7:0] held_q, held_d, byte_q, byte_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (CLK_50M),
    .rst_i       (RST),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .code_o      (code),
    .code_valid_o(code_valid),
    .frame_err_o (frame_err)
  );

  assign ascii = scan_to_ascii(code);

  // A rejected frame breaks any pending prefix sequence, so prefixes are dropped.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    key_d  = key_q;
    held_d = held_q;
    byte_d = byte_q;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (code_valid) begin
      if (code == SC_EXT) begin
        ext_d = 1'b1;
      end else if (code == SC_BRK) begin
        brk_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (key_q && code == held_q) begin
          key_d  = 1'b0;
          held_d = '0;
          byte_d = ASCII_NONE;
        end
      end else if (ascii != ASCII_NONE) begin
        key_d  = 1'b1;
        held_d = code;
        byte_d = ascii;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      key_q  <= 1'b0;
      held_q <= '0;
      byte_q <= ASCII_NONE;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      key_q  <= key_d;
      held_q <= held_d;
      byte_q <= byte_d;
    end
  end

  assign ps2_byte  = byte_q;
  assign ps2_state = key_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames and checks held-key outputs and frame errors.
module tb_ps2_key_decoder;

  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  bit watch = 1'b0;
  bit glitch = 1'b0;

  always #10 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(50000)) dut (
    .CLK_50M  (clk),
    .RST      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_byte (ps2_byte),
    .ps2_state(ps2_state),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (watch && !ps2_state) glitch = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eb, input logic es);
    chk({tag, ".byte"}, {24'd0, ps2_byte}, {24'd0, eb});
    chk({tag, ".state"}, {31'd0, ps2_state}, {31'd0, es});
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HP);
    ps2_clk = 1'b0;
    tick(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input logic stop_b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(stop_b);
    ps2_data = 1'b1;
    tick(HP);
  endtask

  initial begin
    int  e0;
    bit  found;
    logic [7:0] exp_b;
    logic [7:0] c;

    rst = 1'b1;
    tick(5);
    chk_out("reset", 8'h00, 1'b0);
    chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick(5);

    // 1C with exact latency: outputs change on the 4th sample after the stop-bit clock falls
    c = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~^c);
    ps2_data = 1'b1;
    tick(HP);
    ps2_clk = 1'b0;
    tick(3);
    chk_out("lat_before", 8'h00, 1'b0);
    tick(1);
    chk_out("lat_after", 8'h41, 1'b1);
    tick(HP - 4);
    ps2_clk = 1'b1;
    tick(HP);
    chk("make_A.no_err", err_pulses, 0);

    send_frame(8'hF0, 0, 1'b1);
    chk_out("brk_prefix", 8'h41, 1'b1);
    send_frame(8'h1C, 0, 1'b1);
    chk_out("brk_A", 8'h00, 1'b0);

    send_frame(8'h23, 0, 1'b1);
    chk_out("make_D", 8'h44, 1'b1);
    send_frame(8'hF0, 0, 1'b1);
    send_frame(8'h1C, 0, 1'b1);
    chk_out("brk_other", 8'h44, 1'b1);

    e0 = err_pulses;
    send_frame(8'h1D, 1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    exp_b = 8'h44;
    chk("bad_par.err", err_pulses - e0, 1);
`else
    exp_b = 8'h57;
    chk("bad_par.err", err_pulses - e0, 0);
`endif
    chk_out("bad_par", exp_b, 1'b1);

    // partial frame then silence: expect a timeout error
    e0 = err_pulses;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    found = 1'b0;
    for (int i = 0; i < 50300 && !found; i++) begin
      tick(1);
      if (err_pulses != e0) found = 1'b1;
    end
    chk("timeout.seen", {31'd0, found}, 32'd1);
    tick(5);
    chk("timeout.once", err_pulses - e0, 1);
    chk_out("timeout", exp_b, 1'b1);
    send_frame(8'h1B, 0, 1'b1);
    chk_out("after_timeout_S", 8'h53, 1'b1);

    e0 = err_pulses;
    send_frame(8'h23, 0, 1'b0);
    chk("bad_stop.err", err_pulses - e0, 1);
    chk_out("bad_stop", 8'h53, 1'b1);

    send_frame(8'h15, 0, 1'b1);
    chk_out("unmapped", 8'h53, 1'b1);

    watch = 1'b1;
    send_frame(8'h1B, 0, 1'b1);
    watch = 1'b0;
    chk("typematic.glitch", {31'd0, glitch}, 32'd0);
    chk_out("typematic", 8'h53, 1'b1);

    send_frame(8'hE0, 0, 1'b1);
    send_frame(8'h1C, 0, 1'b1);
    chk_out("extended", 8'h53, 1'b1);
    send_frame(8'h1C, 0, 1'b1);
    chk_out("ext_cleared", 8'h41, 1'b1);

    // reset in the middle of a frame
    e0 = err_pulses;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b1;
    tick(3);
    chk_out("mid_rst", 8'h00, 1'b0);
    chk("mid_rst.frame_err", {31'd0, frame_err}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(HP);
    chk("mid_rst.no_err", err_pulses - e0, 0);
    send_frame(8'h23, 0, 1'b1);
    chk_out("resume_D", 8'h44, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
